usr_stim_sequencer: RTL and testbench
=====================================

# usr_stim_sequencer

Programmable stimulus sequencer that sits directly upstream of `universal_shift_reg` and drives its `mode`, `data_in`, `sr` and `sl` inputs from a small command table. On each start it plays back the table one step at a time, holding each step for a programmable number of cycles, so the ILA sees a repeatable, paced sequence. The block replaces hand-toggled VIO control of the shift register. The VIO then only loads the table and issues start/abort.

## Interface
Parameters:
- `DEPTH`, 8: number of table entries. Must be a power of 2 and at least 2. `AW = log2(DEPTH)`.
- `HOLD_W`, 16: width of the per-step hold counter.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  table entry to write.
- `wr_data`  in  8  entry format `{mode[7:6], sr[5], sl[4], data[3:0]}`.
- `hold_cycles`  in  HOLD_W  cycles per step. A value of 0 is treated as 1.
- `num_steps`  in  AW+1  steps to play, 0..DEPTH. Values above DEPTH are clamped to DEPTH.
- `loop_en`  in  1  when set, restart at step 0 after the last step instead of finishing.
- `start`  in  1  level or pulse. Acted on only in IDLE.
- `abort`  in  1  stops playback and returns to IDLE.
- `mode`  out  2  to shift register. Reset value 2'b00 (hold).
- `data_in`  out  4  to shift register. Reset value 0.
- `sr`  out  1  serial-right input. Reset value 0.
- `sl`  out  1  serial-left input. Reset value 0.
- `busy`  out  1  high while playing. Reset value 0.
- `done`  out  1  one-cycle pulse at normal completion. Reset value 0.
- `step_idx`  out  AW  index of the step currently driven. Reset value 0.

## Operation
- Table: DEPTH×8 register array. Asynchronous reset clears every entry to 0.
- Table writes:
  - Accepted only when `busy`=0. Writes while busy are silently dropped.
  - A write at edge T is visible to a start at T+1 or later.
- FSM states: IDLE, RUN.
- In IDLE:
  - Outputs are held at the idle value: mode=00, data_in=0, sr=0, sl=0.
  - `busy`=0 and `step_idx`=0.
- IDLE → RUN when `start`=1, `abort`=0 and the clamped `num_steps` is nonzero.
  - `hold_cycles` (0 mapped to 1), `num_steps` and `loop_en` are latched at this edge.
  - Changes to these inputs during RUN have no effect.
- Start with `num_steps`=0: the FSM stays in IDLE and pulses `done` on the next cycle.
- In RUN:
  - Outputs are registered copies of table[`step_idx`].
  - The hold counter counts 0..H-1. At H-1, `step_idx` advances.
  - After the last step (index N-1): if `loop_en` is latched, return to step 0. Otherwise go to IDLE, assert `done` for 1 cycle and restore idle outputs.
- `abort` wins over every other event:
  - From RUN it goes to IDLE on the next edge with idle outputs and no `done`.
  - In IDLE it suppresses `start`.
- Start while busy is ignored. A held-high `start` re-triggers playback on the first IDLE cycle after `done`.
- Reset mid-sequence: all outputs and state return to their reset values immediately (asynchronous), and the table is cleared.

## Timing
- `start` is sampled at edge T. Entry 0 appears on the outputs and `busy` rises after edge T, i.e. both are visible in cycle T+1.
- Entry k is driven during cycles T+1+k·H through T+(k+1)·H.
- Completion, in cycle T+1+N·H:
  - `done`=1 and `busy`=0.
  - Outputs are idle.
- Back-to-back operation: the earliest restart samples `start` in the `done` cycle, with entry 0 appearing in the following cycle.
- Loop mode: step N-1 is followed immediately by step 0 with no idle gap, and `done` is never asserted.
- All outputs come straight from registers. There is no combinational path from any input to any output.

## Structure
- Package `usr_pkg` holds:
  - Mode constants: `USR_HOLD`=2'b00, `USR_SHR`=2'b01, `USR_SHL`=2'b10, `USR_LOAD`=2'b11.
  - The entry field bit positions.
  - The FSM state enum.
- The same package is shared with `universal_shift_reg` so the mode encoding has one source.
- One natural sub-module: `usr_cmd_table`, the register-array table with write port, asynchronous clear and combinational read.
- The FSM and hold counter stay in the top module.
- Top-level integration: the VIO drives `wr_*`, `hold_cycles`, `num_steps`, `loop_en`, `start` and `abort`. The ILA additionally probes `step_idx`, `busy` and `done`.

## Test plan
- Basic playback:
  - Load `{LOAD,0,0,4'hA}`, `{SHR,1,0,0}` and `{SHL,0,1,0}`. Set H=2, N=3, then start.
  - Required response: outputs match each entry for exactly 2 cycles, starting the cycle after start.
  - Required response: `done` pulses at T+7, and `universal_shift_reg` q goes A→D→B.
- `hold_cycles`=0 with N=2: each step lasts exactly 1 cycle, and `done` pulses at T+3.
- Loop mode:
  - Setup: `loop_en`=1, N=2, H=3.
  - Required response: `step_idx` follows 0,0,0,1,1,1,0… for 20 cycles with no `done`.
  - Then raise `abort`: outputs go idle and `busy`=0 one cycle later, with no `done`.
- Writes and start while busy:
  - Write entry 0 and pulse `start` while busy.
  - Required response: the table is unchanged and the sequence timing is unchanged.
  - After `done`, the write takes effect.
- Boundary cases:
  - `num_steps`=0 → no RUN, and `done` pulses on the next cycle.
  - `num_steps`=15 with DEPTH=8 → clamped to 8 steps.
  - `start` and `abort` together in IDLE → stays IDLE.
- Reset mid-sequence:
  - Assert `rst` between edges during step 2.
  - Required response: outputs and `busy` drop immediately, and every table entry reads back 0 on a subsequent run.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its stimulus sequencer.
// Holds the mode encoding, the command-table entry layout and the sequencer
// FSM state type, so every block agrees on a single encoding.
package usr_pkg;

  // Shift-register mode encoding
  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;
  localparam logic [1:0] USR_SHL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  // Command-table entry layout: {mode[7:6], sr[5], sl[4], data[3:0]}
  localparam int ENT_W       = 8;
  localparam int ENT_MODE_HI = 7;
  localparam int ENT_MODE_LO = 6;
  localparam int ENT_SR      = 5;
  localparam int ENT_SL      = 4;
  localparam int ENT_DATA_HI = 3;
  localparam int ENT_DATA_LO = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_state_e;

  function automatic logic [ENT_W-1:0] usr_entry(input logic [1:0] mode,
                                                 input logic       sr,
                                                 input logic       sl,
                                                 input logic [3:0] data);
    return {mode, sr, sl, data};
  endfunction

endpackage

// File: rtl/usr_cmd_table.sv
// Command table for the stimulus sequencer: DEPTH entries of ENT_W bits.
// Ports:
//   clk, rst            clock, asynchronous active-high clear of every entry
//   i_wr_en/addr/data   synchronous write port (caller gates writes while busy)
//   i_rd_addr           combinational read address
//   o_rd_data           entry at i_rd_addr
module usr_cmd_table
  import usr_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [ENT_W-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [ENT_W-1:0] o_rd_data
);

  logic [ENT_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/usr_stim_sequencer.sv
// Programmable stimulus sequencer for universal_shift_reg. Plays back the
// command table one step at a time, each step held for hold_cycles cycles.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data      table write port (ignored while busy)
//   hold_cycles                cycles per step (0 behaves as 1), latched at start
//   num_steps                  steps to play, clamped to DEPTH, latched at start
//   loop_en                    wrap to step 0 instead of finishing, latched at start
//   start, abort               playback control; abort has priority
//   mode/data_in/sr/sl         registered drive to the shift register
//   busy, done, step_idx       status (all registered)
//
// state   | meaning
// IDLE    | outputs idle, waiting for start
// RUN     | driving table[step_idx], hold counter running
// DEPTH must be a power of two and at least 2.
module usr_stim_sequencer
  import usr_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int HOLD_W = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [AW:0]       num_steps,
  input  logic              loop_en,
  input  logic              start,
  input  logic              abort,
  output logic [1:0]        mode,
  output logic [3:0]        data_in,
  output logic              sr,
  output logic              sl,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     step_idx
);

  localparam logic [AW:0]      DEPTH_V    = (AW+1)'(DEPTH);
  localparam logic [ENT_W-1:0] IDLE_ENTRY = {USR_HOLD, {(ENT_W-2){1'b0}}};

  usr_state_e        r_state, w_state_nxt;
  logic [AW-1:0]     r_step_idx, w_step_nxt;
  logic [HOLD_W-1:0] r_cnt, w_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_m1, w_hold_m1_nxt;
  logic [AW:0]       r_nsteps, w_nsteps_nxt;
  logic              r_loop, w_loop_nxt;
  logic [ENT_W-1:0]  r_out, w_out_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic              w_tbl_wr;
  logic [AW-1:0]     w_rd_addr;
  logic [ENT_W-1:0]  w_rd_data;
  logic [AW:0]       w_n_clamp;
  logic [HOLD_W-1:0] w_hold_m1_in;
  logic              w_last;

  assign w_tbl_wr = wr_en & ~r_busy;

  usr_cmd_table #(.DEPTH(DEPTH)) u_table (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_tbl_wr),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign w_n_clamp    = (num_steps > DEPTH_V) ? DEPTH_V : num_steps;
  // Hold counter runs down from H-1 to 0; hold_cycles of 0 behaves as 1.
  assign w_hold_m1_in = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);
  assign w_last       = ({1'b0, r_step_idx} == (r_nsteps - (AW+1)'(1)));

  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step_idx;
    w_cnt_nxt     = r_cnt;
    w_hold_m1_nxt = r_hold_m1;
    w_nsteps_nxt  = r_nsteps;
    w_loop_nxt    = r_loop;
    w_out_nxt     = r_out;
    w_done_nxt    = 1'b0;
    w_rd_addr     = '0;

    case (r_state)
      ST_IDLE: begin
        w_out_nxt  = IDLE_ENTRY;
        w_step_nxt = '0;
        if (start && !abort) begin
          if (w_n_clamp == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt   = ST_RUN;
            w_hold_m1_nxt = w_hold_m1_in;
            w_cnt_nxt     = w_hold_m1_in;
            w_nsteps_nxt  = w_n_clamp;
            w_loop_nxt    = loop_en;
            w_out_nxt     = w_rd_data;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_out_nxt   = IDLE_ENTRY;
          w_step_nxt  = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - HOLD_W'(1);
        end else if (w_last) begin
          if (r_loop) begin
            w_step_nxt = '0;
            w_cnt_nxt  = r_hold_m1;
            w_out_nxt  = w_rd_data;
          end else begin
            w_state_nxt = ST_IDLE;
            w_out_nxt   = IDLE_ENTRY;
            w_step_nxt  = '0;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_rd_addr  = r_step_idx + AW'(1);
          w_step_nxt = r_step_idx + AW'(1);
          w_cnt_nxt  = r_hold_m1;
          w_out_nxt  = w_rd_data;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_out_nxt   = IDLE_ENTRY;
        w_step_nxt  = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_step_idx <= '0;
      r_cnt      <= '0;
      r_hold_m1  <= '0;
      r_nsteps   <= '0;
      r_loop     <= 1'b0;
      r_out      <= IDLE_ENTRY;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step_idx <= w_step_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hold_m1  <= w_hold_m1_nxt;
      r_nsteps   <= w_nsteps_nxt;
      r_loop     <= w_loop_nxt;
      r_out      <= w_out_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign mode     = r_out[ENT_MODE_HI:ENT_MODE_LO];
  assign sr       = r_out[ENT_SR];
  assign sl       = r_out[ENT_SL];
  assign data_in  = r_out[ENT_DATA_HI:ENT_DATA_LO];
  assign busy     = r_busy;
  assign done     = r_done;
  assign step_idx = r_step_idx;

endmodule

// File: tb/tb_usr_stim_sequencer.sv
// Self-checking bench for usr_stim_sequencer. Expected per-cycle outputs are
// computed from the playback rules (entry = floor(j/H), done at j = N*H).
module tb_usr_stim_sequencer;
  import usr_pkg::*;

  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int HOLD_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;
  logic [HOLD_W-1:0] hold_cycles;
  logic [AW:0]       num_steps;
  logic              loop_en;
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [3:0]        data_in;
  logic              sr;
  logic              sl;
  logic              busy;
  logic              done;
  logic [AW-1:0]     step_idx;

  always #5 clk = ~clk;

  usr_stim_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .hold_cycles (hold_cycles),
    .num_steps   (num_steps),
    .loop_en     (loop_en),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .data_in     (data_in),
    .sr          (sr),
    .sl          (sl),
    .busy        (busy),
    .done        (done),
    .step_idx    (step_idx)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mem [DEPTH];

  typedef struct {
    string name;
    int    h;
    int    n;
    int    done_j;
  } vec_t;
  vec_t vecs [7];

  // Observed vector: {busy, done, step_idx, mode, sr, sl, data_in}
  function automatic logic [12:0] obs();
    return {busy, done, step_idx, mode, sr, sl, data_in};
  endfunction

  // Expected vector for cycle T+1+j after a start sampled at edge T.
  function automatic logic [12:0] exp_at(input int j, input int h, input int n, input bit lp);
    int heff, neff, k;
    heff = (h == 0) ? 1 : h;
    neff = (n > DEPTH) ? DEPTH : n;
    if (lp && neff > 0) begin
      k = (j / heff) % neff;
      return {1'b1, 1'b0, 3'(k), mem[k]};
    end
    if (j < neff * heff) begin
      k = j / heff;
      return {1'b1, 1'b0, 3'(k), mem[k]};
    end
    if (j == neff * heff) return {1'b0, 1'b1, 11'd0};
    return 13'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; writes one entry while idle and tracks it in mem.
  task automatic wr(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mem[a] = d;
  endtask

  // Called at a negedge; starts playback and checks ncyc cycles after it.
  // Optionally injects a write plus a start pulse at cycle inj_j.
  task automatic run_seq(input string tag, input int h, input int n, input bit lp,
                         input int ncyc, input int exp_done,
                         input int inj_j = -1, input logic [2:0] inj_addr = 3'd0,
                         input logic [7:0] inj_data = 8'd0);
    hold_cycles = HOLD_W'(h);
    num_steps   = 4'(n);
    loop_en     = lp;
    start       = 1'b1;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (j == 0) begin
        // Latched at start: later changes must have no effect.
        hold_cycles = HOLD_W'($urandom);
        num_steps   = 4'($urandom);
        loop_en     = 1'($urandom);
      end
      chk({tag, "_vec"}, 32'(obs()), 32'(exp_at(j, h, n, lp)));
      if (exp_done >= 0) chk({tag, "_done_time"}, 32'(done), 32'(j == exp_done));
      if (j == inj_j) begin
        wr_en   = 1'b1;
        wr_addr = inj_addr;
        wr_data = inj_data;
        start   = 1'b1;
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic abort_chk(input string tag);
    abort = 1'b1;
    @(negedge clk);
    chk({tag, "_abort"}, 32'(obs()), 32'd0);
    abort = 1'b0;
    @(negedge clk);
    chk({tag, "_abort_after"}, 32'(obs()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, n, nc, nw, heff, neff;
    bit lp;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    hold_cycles = '0; num_steps = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 32'(obs()), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    wr(0, usr_entry(USR_LOAD, 1'b0, 1'b0, 4'hA));
    wr(1, usr_entry(USR_SHR, 1'b1, 1'b0, 4'h0));
    wr(2, usr_entry(USR_SHL, 1'b0, 1'b1, 4'h0));
    wr(3, 8'h13); wr(4, 8'h2C); wr(5, 8'hB5); wr(6, 8'h47); wr(7, 8'hF9);
    chk("entry0_fmt", 32'(mem[0]), 32'h0CA);

    vecs[0] = '{"basic",   2, 3,  6};
    vecs[1] = '{"hold0",   0, 2,  2};
    vecs[2] = '{"nsteps0", 3, 0,  0};
    vecs[3] = '{"clamp15", 1, 15, 8};
    vecs[4] = '{"full",    3, 8,  24};
    vecs[5] = '{"single",  4, 1,  4};
    vecs[6] = '{"clamp9",  1, 9,  8};
    for (int v = 0; v < 7; v++) begin
      run_seq(vecs[v].name, vecs[v].h, vecs[v].n, 1'b0, vecs[v].done_j + 2, vecs[v].done_j);
    end

    // Loop mode for 20 cycles, then abort.
    run_seq("loop", 3, 2, 1'b1, 20, -1);
    abort_chk("loop");

    // Start and abort together while idle.
    hold_cycles = 16'd2; num_steps = 4'd3; start = 1'b1; abort = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("start_abort_idle", 32'(obs()), 32'd0);
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clk);

    // Held-high start: restart sampled in the done cycle.
    hold_cycles = 16'd1; num_steps = 4'd2; loop_en = 1'b0; start = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("held_start", 32'(obs()), 32'(exp_at(j % 3, 1, 2, 1'b0)));
    end
    start = 1'b0;
    @(negedge clk);
    chk("held_start_release", 32'(obs()), 32'd0);

    // Write and start while busy are dropped; a write after done takes effect.
    run_seq("busy_wr", 2, 3, 1'b0, 8, 6, 1, 3'd0, 8'h55);
    run_seq("busy_wr_old", 1, 1, 1'b0, 3, 1);
    wr(0, 8'h55);
    run_seq("after_wr", 1, 1, 1'b0, 3, 1);
    chk("after_wr_entry", 32'(mem[0]), 32'h055);

    // Asynchronous reset during step 2.
    run_seq("pre_rst", 2, 3, 1'b0, 5, -1);
    chk("pre_rst_step", 32'(step_idx), 32'd2);
    #2 rst = 1'b1;
    #1 chk("rst_async", 32'(obs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'd0;
    @(negedge clk);
    run_seq("post_rst", 1, 8, 1'b0, 10, 8);

    // Randomized runs against the reference model.
    for (int it = 0; it < 25; it++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) wr($urandom_range(0, DEPTH - 1), 8'($urandom));
      h  = $urandom_range(0, 4);
      n  = $urandom_range(0, 15);
      lp = ($urandom_range(0, 3) == 0);
      heff = (h == 0) ? 1 : h;
      neff = (n > DEPTH) ? DEPTH : n;
      if (lp && neff > 0) begin
        nc = $urandom_range(5, 20);
        run_seq("rand_loop", h, n, 1'b1, nc, -1);
        abort_chk("rand_loop");
      end else begin
        run_seq("rand", h, n, lp, neff * heff + 2, neff * heff);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
